// File: rtl/dp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dp_pkg
// Brief    : Shared state encoding and default widths for the dot-product master.
// Revision : 1.0 - initial release
// ============================================================================
package dp_pkg;

    localparam int c_DEF_ADDR_WIDTH = 16;
    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_LEN_WIDTH  = 8;
    localparam int c_DEF_ACC_WIDTH  = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_A    = 3'd1,
        RD_B    = 3'd2,
        MAC     = 3'd3,
        WR_REQ  = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } dp_state_t;

endpackage
`default_nettype wire

// File: rtl/dot_product_master_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dp_mac
// Brief    : Unsigned multiply-accumulate register, wraps modulo 2^ACC_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module dp_mac
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = c_DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]    r_acc;

    assign w_prod = {{DATA_WIDTH{1'b0}}, i_op_a} * {{DATA_WIDTH{1'b0}}, i_op_b};

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_WIDTH'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/dot_product_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dot_product_master
// Brief    : Fetches A/B vectors over the read channel, accumulates the dot
//            product and writes it back little-endian over the write channel.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_master
    import dp_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = c_DEF_LEN_WIDTH,
    parameter int ACC_WIDTH  = c_DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [ADDR_WIDTH-1:0] res_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int c_NUM_BYTES = ACC_WIDTH / DATA_WIDTH;
    localparam int c_K_WIDTH   = (c_NUM_BYTES > 1) ? $clog2(c_NUM_BYTES) : 1;

    dp_state_t              r_state, w_state_next;
    logic [ADDR_WIDTH-1:0]  r_base_a, w_base_a_next;
    logic [ADDR_WIDTH-1:0]  r_base_b, w_base_b_next;
    logic [ADDR_WIDTH-1:0]  r_res_addr, w_res_addr_next;
    logic [LEN_WIDTH-1:0]   r_len, w_len_next;
    logic [LEN_WIDTH-1:0]   r_idx, w_idx_next;
    logic [c_K_WIDTH-1:0]   r_k, w_k_next;
    logic [DATA_WIDTH-1:0]  r_op_a, w_op_a_next;
    logic [DATA_WIDTH-1:0]  r_op_b, w_op_b_next;
    logic                   r_arvalid, w_arvalid_next;
    logic                   r_awvalid, w_awvalid_next;
    logic                   r_wvalid, w_wvalid_next;
    logic [ACC_WIDTH-1:0]   r_result, w_result_next;
    logic [ACC_WIDTH-1:0]   w_acc;
    logic                   w_acc_clr;
    logic                   w_acc_en;
    logic [DATA_WIDTH-1:0]  w_wdata;

    dp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_acc_clr),
        .i_en   (w_acc_en),
        .i_op_a (r_op_a),
        .i_op_b (r_op_b),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_res_addr <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_k        <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_arvalid  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_result   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_base_a   <= w_base_a_next;
            r_base_b   <= w_base_b_next;
            r_res_addr <= w_res_addr_next;
            r_len      <= w_len_next;
            r_idx      <= w_idx_next;
            r_k        <= w_k_next;
            r_op_a     <= w_op_a_next;
            r_op_b     <= w_op_b_next;
            r_arvalid  <= w_arvalid_next;
            r_awvalid  <= w_awvalid_next;
            r_wvalid   <= w_wvalid_next;
            r_result   <= w_result_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_base_a_next   = r_base_a;
        w_base_b_next   = r_base_b;
        w_res_addr_next = r_res_addr;
        w_len_next      = r_len;
        w_idx_next      = r_idx;
        w_k_next        = r_k;
        w_op_a_next     = r_op_a;
        w_op_b_next     = r_op_b;
        w_arvalid_next  = r_arvalid;
        w_awvalid_next  = r_awvalid;
        w_wvalid_next   = r_wvalid;
        w_result_next   = r_result;
        w_acc_clr       = 1'b0;
        w_acc_en        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_base_a_next   = base_a;
                    w_base_b_next   = base_b;
                    w_res_addr_next = res_addr;
                    w_len_next      = len;
                    w_idx_next      = '0;
                    w_k_next        = '0;
                    w_acc_clr       = 1'b1;
                    if (len != '0) begin
                        w_state_next   = RD_A;
                        w_arvalid_next = 1'b1;
                    end else begin
                        w_state_next   = WR_REQ;
                        w_awvalid_next = 1'b1;
                        w_wvalid_next  = 1'b1;
                    end
                end
            end
            RD_A: begin
                if (r_arvalid && arready) begin
                    w_arvalid_next = 1'b0;
                end
                if (rvalid) begin
                    w_op_a_next    = rdata;
                    w_state_next   = RD_B;
                    w_arvalid_next = 1'b1;
                end
            end
            RD_B: begin
                if (r_arvalid && arready) begin
                    w_arvalid_next = 1'b0;
                end
                if (rvalid) begin
                    w_op_b_next  = rdata;
                    w_state_next = MAC;
                end
            end
            MAC: begin
                w_acc_en   = 1'b1;
                w_idx_next = r_idx + LEN_WIDTH'(1);
                if (r_idx + LEN_WIDTH'(1) == r_len) begin
                    w_state_next   = WR_REQ;
                    w_awvalid_next = 1'b1;
                    w_wvalid_next  = 1'b1;
                end else begin
                    w_state_next   = RD_A;
                    w_arvalid_next = 1'b1;
                end
            end
            WR_REQ: begin
                // Address and data handshakes may complete in either order
                w_awvalid_next = r_awvalid & ~awready;
                w_wvalid_next  = r_wvalid & ~wready;
                if (!w_awvalid_next && !w_wvalid_next) begin
                    w_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    if (r_k == c_K_WIDTH'(c_NUM_BYTES - 1)) begin
                        // k stays on the last byte so the write outputs remain in range
                        w_state_next  = DONE;
                        w_result_next = w_acc;
                    end else begin
                        w_k_next       = r_k + c_K_WIDTH'(1);
                        w_state_next   = WR_REQ;
                        w_awvalid_next = 1'b1;
                        w_wvalid_next  = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_wdata = '0;
        for (int b = 0; b < c_NUM_BYTES; b++) begin
            if (r_k == c_K_WIDTH'(b)) begin
                w_wdata = w_acc[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign araddr  = ((r_state == RD_B) ? r_base_b : r_base_a) + ADDR_WIDTH'(r_idx);
    assign arvalid = r_arvalid;
    assign rready  = (r_state == RD_A) || (r_state == RD_B);
    assign awaddr  = r_res_addr + ADDR_WIDTH'(r_k);
    assign awvalid = r_awvalid;
    assign wdata   = w_wdata;
    assign wvalid  = r_wvalid;
    assign bready  = (r_state == WR_RESP);
    assign done    = (r_state == DONE);
    assign busy    = (r_state != IDLE) && (r_state != DONE);
    assign result  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_master
// Brief    : Randomised-stall memory slave plus scoreboard for dot_product_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_master;

    typedef struct {
        logic [23:0] res;
        logic [15:0] res_addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_a = '0, base_b = '0, res_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done, awvalid, wvalid, bready, arvalid, rready;
    logic [23:0] result;
    logic [15:0] awaddr, araddr;
    logic [7:0]  wdata;

    logic        s_arready, s_rvalid, s_ar_pend;
    logic [7:0]  s_rdata;
    logic [15:0] s_raddr;
    logic        s_awready, s_wready, s_aw_got, s_w_got, s_bvalid;

    logic [7:0]  img  [0:65535];
    logic [7:0]  wmem [0:65535];

    exp_t        exp_q[$];
    logic [15:0] rd_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ar_count = 0;

    always #5 clk = ~clk;

    dot_product_master dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_a   (base_a),
        .base_b   (base_b),
        .res_addr (res_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (s_awready),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (s_wready),
        .bvalid   (s_bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (s_arready),
        .rdata    (s_rdata),
        .rvalid   (s_rvalid),
        .rready   (rready)
    );

    // Read slave: random arready/rvalid stalls, data from the preloaded image
    always @(posedge clk) begin
        if (rst) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_ar_pend <= 1'b0;
            s_rdata   <= '0;
            s_raddr   <= '0;
        end else begin
            if (arvalid && s_arready) begin
                s_arready <= 1'b0;
                s_ar_pend <= 1'b1;
                s_raddr   <= araddr;
            end else if (arvalid && !s_ar_pend && !s_rvalid && $urandom_range(0, 2) != 0) begin
                s_arready <= 1'b1;
            end
            if (s_ar_pend && !s_rvalid && $urandom_range(0, 2) != 0) begin
                s_rvalid  <= 1'b1;
                s_rdata   <= img[s_raddr];
                s_ar_pend <= 1'b0;
            end
            if (s_rvalid && rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // Write slave: uses the live awaddr/wdata when it commits the write
    always @(posedge clk) begin
        if (rst) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_aw_got  <= 1'b0;
            s_w_got   <= 1'b0;
            s_bvalid  <= 1'b0;
        end else begin
            if (awvalid && s_awready) begin
                s_awready <= 1'b0;
                s_aw_got  <= 1'b1;
            end else if (awvalid && !s_aw_got && !s_bvalid && $urandom_range(0, 2) != 0) begin
                s_awready <= 1'b1;
            end
            if (wvalid && s_wready) begin
                s_wready <= 1'b0;
                s_w_got  <= 1'b1;
            end else if (wvalid && !s_w_got && !s_bvalid && $urandom_range(0, 2) != 0) begin
                s_wready <= 1'b1;
            end
            if (s_aw_got && s_w_got && !s_bvalid && $urandom_range(0, 2) != 0) begin
                wmem[awaddr] <= wdata;
                s_bvalid     <= 1'b1;
                s_aw_got     <= 1'b0;
                s_w_got      <= 1'b0;
            end
            if (s_bvalid && bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: read addresses, channel exclusivity and completed results
    initial begin
        exp_t        e;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (arvalid && s_arready) begin
                    ar_count++;
                    if (rd_q.size() == 0) begin
                        check("unexpected_read", {48'd0, araddr}, 64'hFFFF_FFFF);
                    end else begin
                        a = rd_q.pop_front();
                        check("araddr", {48'd0, araddr}, {48'd0, a});
                    end
                end
                if (arvalid && (awvalid || wvalid)) begin
                    check("channel_overlap", 64'd1, 64'd0);
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {40'd0, result}, {40'd0, e.res});
                        for (int b = 0; b < 3; b++) begin
                            check("wb_byte", {56'd0, wmem[16'(e.res_addr + 16'(b))]},
                                  {56'd0, e.res[8*b +: 8]});
                        end
                        check("reads_left", 64'(rd_q.size()), 64'd0);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {57'd0, busy, done, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        check({tag, "_result"}, {40'd0, result}, 64'd0);
        check({tag, "_addr"}, {32'd0, awaddr, araddr}, 64'd0);
        check({tag, "_wdata"}, {56'd0, wdata}, 64'd0);
    endtask

    task automatic load_vec(input logic [15:0] base, input int n, input logic [7:0] v0,
                            input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            img[16'(base + 16'(i))] = 8'(v0 + 8'(i) * step);
        end
    endtask

    task automatic run(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] ra,
                       input logic [7:0] ln, input bit repulse);
        exp_t   e;
        longint acc;
        int     ar0;
        bit     seen;
        acc = 0;
        for (int i = 0; i < int'(ln); i++) begin
            acc = acc + longint'(img[16'(ba + 16'(i))]) * longint'(img[16'(bb + 16'(i))]);
            rd_q.push_back(16'(ba + 16'(i)));
            rd_q.push_back(16'(bb + 16'(i)));
        end
        e.res      = acc[23:0];
        e.res_addr = ra;
        exp_q.push_back(e);
        @(negedge clk);
        base_a   = ba;
        base_b   = bb;
        res_addr = ra;
        len      = ln;
        start    = 1'b1;
        ar0      = ar_count;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else if (repulse && c == 4) begin
                base_a   = 16'h1234;
                base_b   = 16'h4321;
                res_addr = 16'h0700;
                len      = 8'd7;
                start    = 1'b1;
            end
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("read_count", 64'(ar_count - ar0), 64'(2 * int'(ln)));
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 65536; i++) begin
            img[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        load_vec(16'h0000, 3, 8'd1, 8'd1);
        load_vec(16'h0100, 3, 8'd4, 8'd1);
        run(16'h0000, 16'h0100, 16'h0200, 8'd3, 1'b0);
        run(16'h0000, 16'h0100, 16'h0200, 8'd0, 1'b0);

        load_vec(16'h2000, 5, 8'd10, 8'd7);
        load_vec(16'h2100, 5, 8'd200, 8'd3);
        run(16'h0000, 16'h0100, 16'h0210, 8'd3, 1'b1);
        run(16'h2000, 16'h2100, 16'h0220, 8'd5, 1'b0);

        load_vec(16'h0000, 4, 8'hFF, 8'd0);
        load_vec(16'h0100, 4, 8'hFF, 8'd0);
        run(16'h0000, 16'h0100, 16'h0230, 8'd4, 1'b0);

        img[16'hFFFE] = 8'd7;
        img[16'hFFFF] = 8'd9;
        load_vec(16'h1000, 3, 8'd2, 8'd1);
        run(16'hFFFE, 16'h1000, 16'h0240, 8'd3, 1'b0);

        // Abort during the B fetch, then a clean rerun
        load_vec(16'h0000, 3, 8'd1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            rd_q.push_back(16'(i));
            rd_q.push_back(16'(16'h0100 + 16'(i)));
        end
        @(negedge clk);
        base_a   = 16'h0000;
        base_b   = 16'h0100;
        res_addr = 16'h0300;
        len      = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (arvalid && araddr == 16'h0100) begin
                found = 1'b1;
            end
        end
        check("reach_rd_b", {63'd0, found}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        rd_q.delete();
        exp_q.delete();
        run(16'h0000, 16'h0100, 16'h0200, 8'd3, 1'b0);

        for (int t = 0; t < 6; t++) begin
            logic [15:0] ba;
            logic [7:0]  ln;
            ba = 16'($urandom_range(0, 65535));
            ln = 8'($urandom_range(1, 10));
            for (int i = 0; i < int'(ln); i++) begin
                img[16'(ba + 16'(i))]           = 8'($urandom);
                img[16'(ba + 16'h0400 + 16'(i))] = 8'($urandom);
            end
            run(ba, 16'(ba + 16'h0400), 16'(16'h8000 + 16'(t * 8)), ln, t[0]);
        end

        repeat (5) @(negedge clk);
        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
